// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low-side drive with programmable dead time, one
// independent state machine and down-counter per PWM channel.
module pwm_deadtime_gen #(
  parameter int unsigned CH_NUM   = 4,
  parameter int unsigned DT_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                en_i,
  input  logic [DT_WIDTH-1:0] dt_i,
  input  logic [CH_NUM-1:0]   pwm_i,
  output logic [CH_NUM-1:0]   pwm_h_o,
  output logic [CH_NUM-1:0]   pwm_l_o,
  output logic [CH_NUM-1:0]   busy_o
);

  typedef enum logic [2:0] {
    OFF,
    LO,
    DT_LH,
    HI,
    DT_HL
  } state_t;

  state_t              state_q [CH_NUM];
  state_t              state_d [CH_NUM];
  logic [DT_WIDTH-1:0] cnt_q   [CH_NUM];
  logic [DT_WIDTH-1:0] cnt_d   [CH_NUM];

  logic                dt_zero;
  logic [DT_WIDTH-1:0] dt_load;

  assign dt_zero = (dt_i == '0);
  assign dt_load = dt_i - DT_WIDTH'(1);

  always_comb begin
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!en_i) begin
        state_d[i] = OFF;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          OFF: begin
            if (pwm_i[i]) state_d[i] = dt_zero ? HI : DT_LH;
            else          state_d[i] = dt_zero ? LO : DT_HL;
            cnt_d[i] = dt_zero ? '0 : dt_load;
          end
          LO: begin
            if (pwm_i[i]) begin
              state_d[i] = dt_zero ? HI : DT_LH;
              cnt_d[i]   = dt_zero ? '0 : dt_load;
            end
          end
          HI: begin
            if (!pwm_i[i]) begin
              state_d[i] = dt_zero ? LO : DT_HL;
              cnt_d[i]   = dt_zero ? '0 : dt_load;
            end
          end
          // A request that collapses inside the window falls back to the
          // side that was driven before, so the short pulse never appears.
          DT_LH: begin
            if (!pwm_i[i]) begin
              state_d[i] = LO;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == '0) begin
              state_d[i] = HI;
            end else begin
              cnt_d[i] = cnt_q[i] - DT_WIDTH'(1);
            end
          end
          DT_HL: begin
            if (pwm_i[i]) begin
              state_d[i] = HI;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == '0) begin
              state_d[i] = LO;
            end else begin
              cnt_d[i] = cnt_q[i] - DT_WIDTH'(1);
            end
          end
          default: begin
            state_d[i] = OFF;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Outputs are registered from the next state so they equal a decode of
  // the state register without any combinational glitching.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (!rst_n_i) begin
        state_q[i] <= OFF;
        cnt_q[i]   <= '0;
        pwm_h_o[i] <= 1'b0;
        pwm_l_o[i] <= 1'b0;
        busy_o[i]  <= 1'b0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pwm_h_o[i] <= (state_d[i] == HI);
        pwm_l_o[i] <= (state_d[i] == LO);
        busy_o[i]  <= (state_d[i] == DT_LH) || (state_d[i] == DT_HL);
      end
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Randomized and directed bench for pwm_deadtime_gen against a per-channel
// behavioural model of output level and remaining dead cycles.
module tb_pwm_deadtime_gen;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] dt;
  logic [CH-1:0] pwm;
  logic [CH-1:0] pwm_h;
  logic [CH-1:0] pwm_l;
  logic [CH-1:0] busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model: 0 = off, 1 = low side, 2 = high side, 3 = dead window.
  int mode [CH];
  int tgt  [CH];
  int rem  [CH];

  pwm_deadtime_gen #(.CH_NUM(CH), .DT_WIDTH(DW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .en_i    (en),
    .dt_i    (dt),
    .pwm_i   (pwm),
    .pwm_h_o (pwm_h),
    .pwm_l_o (pwm_l),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic start_to(input int c, input int level);
    if (dt == 0) begin
      mode[c] = level ? 2 : 1;
    end else begin
      mode[c] = 3;
      tgt[c]  = level;
      rem[c]  = int'(dt);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      if (!rst_n || !en) begin
        mode[c] = 0;
      end else begin
        case (mode[c])
          0: start_to(c, int'(pwm[c]));
          1: if (pwm[c])  start_to(c, 1);
          2: if (!pwm[c]) start_to(c, 0);
          default: begin
            if (int'(pwm[c]) != tgt[c]) begin
              mode[c] = tgt[c] ? 1 : 2;
            end else begin
              rem[c]--;
              if (rem[c] == 0) mode[c] = tgt[c] ? 2 : 1;
            end
          end
        endcase
      end
    end
  endtask

  // One clock: DUT and model consume the same inputs, outputs compared at negedge.
  task automatic cycle();
    logic [CH-1:0] eh, el, eb;
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      eh[c] = (mode[c] == 2);
      el[c] = (mode[c] == 1);
      eb[c] = (mode[c] == 3);
    end
    check("pwm_h", 32'(pwm_h), 32'(eh));
    check("pwm_l", 32'(pwm_l), 32'(el));
    check("busy",  32'(busy),  32'(eb));
    check("no_overlap", 32'(pwm_h & pwm_l), 32'd0);
  endtask

  task automatic run_random(input int n, input int dt_max, input int flip_pct, input int en_off_pct);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(99) < flip_pct) pwm[c] = ~pwm[c];
      if ($urandom_range(99) < 10) dt = DW'($urandom_range(dt_max));
      en    = ($urandom_range(99) >= en_off_pct);
      rst_n = ($urandom_range(199) != 0);
      cycle();
    end
  endtask

  int acc;

  initial begin
    for (int c = 0; c < CH; c++) begin
      mode[c] = 0; tgt[c] = 0; rem[c] = 0;
    end
    rst_n = 1'b0; en = 1'b1; dt = 8'd3; pwm = 4'hF;
    @(negedge clk);
    repeat (3) cycle();
    check("reset_outputs", 32'({pwm_h, pwm_l, busy}), 32'd0);

    // Rising edge on channel 0 with dt=3.
    rst_n = 1'b1; pwm = 4'h0;
    repeat (4) cycle();
    pwm[0] = 1'b1;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (busy[0]) acc++;
    end
    check("dt3_busy_cycles", 32'(acc), 32'd3);
    check("dt3_high_after", 32'(pwm_h[0]), 32'd1);

    // dt=0, channel 1 toggles every cycle.
    dt = 8'd0; pwm[1] = 1'b0;
    repeat (2) cycle();
    for (int k = 0; k < 12; k++) begin
      pwm[1] = ~pwm[1];
      cycle();
      check("dt0_follow", 32'(pwm_h[1]), 32'(pwm[1]));
    end

    // dt=4, 2-cycle high pulse on channel 2 from LO is swallowed.
    dt = 8'd4; pwm[2] = 1'b0;
    repeat (6) cycle();
    acc = 0;
    pwm[2] = 1'b1;
    for (int k = 0; k < 2; k++) begin cycle(); acc |= int'(pwm_h[2]); end
    pwm[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin cycle(); acc |= int'(pwm_h[2]); end
    check("glitch_no_high", 32'(acc), 32'd0);

    // In HI with dt=5, drop enable, then re-enable.
    dt = 8'd5; pwm[3] = 1'b1;
    repeat (8) cycle();
    en = 1'b0;
    cycle();
    check("en_off_h3", 32'(pwm_h[3]), 32'd0);
    en = 1'b1;
    repeat (7) cycle();

    // dt changed mid-window keeps the running count.
    pwm[0] = 1'b0;
    repeat (8) cycle();
    pwm[0] = 1'b1;
    cycle();
    dt = 8'd1;
    repeat (6) cycle();
    pwm[0] = 1'b0;
    repeat (3) cycle();

    // Maximum dead time with a long request.
    dt = 8'd255; pwm = 4'h0;
    repeat (4) cycle();
    pwm = 4'hF;
    repeat (300) cycle();
    check("dtmax_high", 32'(pwm_h), 32'hF);

    pwm = 4'h0; dt = 8'd2;
    run_random(1500, 6, 30, 2);
    run_random(1500, 3, 60, 1);
    run_random(800, 20, 8, 1);
    rst_n = 1'b1; en = 1'b1;
    run_random(500, 0, 50, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
